// File: rtl/puf_auth_ctrl.sv
// Ring-oscillator PUF challenge/response controller with enroll and authenticate modes.
// Ports: clk, rst_n, start, mode, thresh in; chal, osc_en, osc_clr out; cnt_a, cnt_b in;
//        busy, done, response, hd, match, key_valid, err out. All outputs registered.
module puf_auth_ctrl #(
    parameter int N_CHAL = 32,
    parameter int CHAL_W = 5,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [CHAL_W:0]   thresh,
    output logic [CHAL_W-1:0] chal,
    output logic              osc_en,
    output logic              osc_clr,
    input  logic [CNT_W-1:0]  cnt_a,
    input  logic [CNT_W-1:0]  cnt_b,
    output logic              busy,
    output logic              done,
    output logic [N_CHAL-1:0] response,
    output logic [CHAL_W:0]   hd,
    output logic              match,
    output logic              key_valid,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        SAMPLE,
        DONE
    } state_t;

    localparam int PH_W = $clog2(WINDOW + 1);
    localparam logic [PH_W-1:0]   WIN_LAST  = PH_W'(WINDOW - 1);
    localparam logic [PH_W-1:0]   CLR_LAST  = PH_W'(1);
    localparam logic [CHAL_W-1:0] CHAL_LAST = CHAL_W'(N_CHAL - 1);

    state_t            state;
    logic [PH_W-1:0]   phase;
    logic              mode_q;
    logic [CHAL_W:0]   thresh_q;
    logic [N_CHAL-1:0] key;

    logic              bit_s;
    logic              diff;
    logic [N_CHAL-1:0] resp_nxt;
    logic [CHAL_W:0]   hd_nxt;

    // Response bits are cleared at start, so OR-ing in the new bit is a write.
    always_comb begin
        bit_s    = cnt_a > cnt_b;
        diff     = (bit_s ^ key[chal]) & mode_q;
        resp_nxt = response | (N_CHAL'(bit_s) << chal);
        hd_nxt   = hd + {{CHAL_W{1'b0}}, diff};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            mode_q    <= 1'b0;
            thresh_q  <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            chal      <= '0;
            osc_en    <= 1'b0;
            osc_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            response  <= '0;
            hd        <= '0;
            match     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        thresh_q <= thresh;
                        response <= '0;
                        hd       <= '0;
                        match    <= 1'b0;
                        err      <= 1'b0;
                        chal     <= '0;
                        phase    <= '0;
                        osc_clr  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (phase == CLR_LAST) begin
                        phase   <= '0;
                        osc_clr <= 1'b0;
                        osc_en  <= 1'b1;
                        state   <= COUNT;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                COUNT: begin
                    if (phase == WIN_LAST) begin
                        phase  <= '0;
                        osc_en <= 1'b0;
                        state  <= SAMPLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                SAMPLE: begin
                    response <= resp_nxt;
                    hd       <= hd_nxt;
                    if (chal == CHAL_LAST) begin
                        // Verdict is settled on entry to DONE so it is
                        // visible together with the done pulse.
                        done  <= 1'b1;
                        state <= DONE;
                        if (!mode_q) begin
                            key       <= resp_nxt;
                            key_valid <= 1'b1;
                            match     <= 1'b0;
                        end else if (key_valid) begin
                            match <= (hd_nxt <= thresh_q);
                            err   <= 1'b0;
                        end else begin
                            match <= 1'b0;
                            err   <= 1'b1;
                        end
                    end else begin
                        chal    <= chal + 1'b1;
                        osc_clr <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    chal  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Self-checking bench for puf_auth_ctrl: directed plan steps plus randomized runs
// checked against a per-run model of response, key, Hamming distance and verdict.
module tb_puf_auth_ctrl;

    localparam int N_CHAL = 32;
    localparam int CHAL_W = 5;
    localparam int CNT_W  = 16;
    localparam int WINDOW = 4;
    localparam int DONE_CYC = 1 + N_CHAL * (WINDOW + 3);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              mode;
    logic [CHAL_W:0]   thresh;
    logic [CHAL_W-1:0] chal;
    logic              osc_en;
    logic              osc_clr;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic              busy;
    logic              done;
    logic [N_CHAL-1:0] response;
    logic [CHAL_W:0]   hd;
    logic              match;
    logic              key_valid;
    logic              err;

    puf_auth_ctrl #(
        .N_CHAL(N_CHAL),
        .CHAL_W(CHAL_W),
        .CNT_W (CNT_W),
        .WINDOW(WINDOW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .thresh   (thresh),
        .chal     (chal),
        .osc_en   (osc_en),
        .osc_clr  (osc_clr),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .busy     (busy),
        .done     (done),
        .response (response),
        .hd       (hd),
        .match    (match),
        .key_valid(key_valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Oscillator bank stand-in: counts per challenge index.
    logic [CNT_W-1:0] ra [N_CHAL];
    logic [CNT_W-1:0] rb [N_CHAL];
    assign cnt_a = ra[chal];
    assign cnt_b = rb[chal];

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    logic [N_CHAL-1:0] exp_bits;
    logic [N_CHAL-1:0] key_m;
    bit                kv_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bits: intended outcome per challenge; rnd picks random counts.
    task automatic set_pattern(input logic [N_CHAL-1:0] bits, input bit rnd, input bit tie);
        int a, b;
        exp_bits = tie ? '0 : bits;
        for (int k = 0; k < N_CHAL; k++) begin
            if (tie) begin
                a = 'hFFFF;
                b = 'hFFFF;
            end else if (!rnd) begin
                a = bits[k] ? 10 : 3;
                b = bits[k] ? 5 : 9;
            end else if (bits[k]) begin
                b = int'($urandom_range(0, 65534));
                a = int'($urandom_range(b + 1, 65535));
            end else begin
                a = int'($urandom_range(0, 65535));
                b = int'($urandom_range(a, 65535));
            end
            ra[k] = CNT_W'(a);
            rb[k] = CNT_W'(b);
        end
    endtask

    task automatic run(input string nm, input bit md, input logic [CHAL_W:0] th,
                       input bit poke);
        int dcyc, bad, gap;
        int nclr[N_CHAL];
        int nen[N_CHAL];
        bit poked;
        int ehd;
        bit ematch, eerr;
        for (int k = 0; k < N_CHAL; k++) begin
            nclr[k] = 0;
            nen[k]  = 0;
        end
        dcyc  = -1;
        gap   = 0;
        poked = 0;
        @(negedge clk);
        mode   = md;
        thresh = th;
        start  = 1'b1;
        for (int cyc = 1; cyc <= 3 * DONE_CYC; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            mode  = md;
            if (osc_clr) nclr[chal]++;
            if (osc_en) nen[chal]++;
            if (!busy) gap++;
            if (poke && !poked && osc_en && chal == 3) begin
                start = 1'b1;
                mode  = ~md;
                poked = 1;
            end
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        bad = 0;
        for (int k = 0; k < N_CHAL; k++)
            if (nclr[k] != 2 || nen[k] != WINDOW) bad++;

        ehd    = 0;
        ematch = 0;
        eerr   = 0;
        if (!md) begin
            key_m = exp_bits;
            kv_m  = 1;
        end else if (kv_m) begin
            ehd    = $countones(exp_bits ^ key_m);
            ematch = (ehd <= int'(th));
        end else begin
            eerr = 1;
        end

        chk({nm, " done_cycle"}, 64'(dcyc), 64'(DONE_CYC));
        chk({nm, " pulse_widths"}, 64'(bad), 64'd0);
        chk({nm, " busy_gap"}, 64'(gap), 64'd0);
        chk({nm, " response"}, 64'(response), 64'(exp_bits));
        if (kv_m || !md)
            chk({nm, " hd"}, 64'(hd), 64'(ehd));
        chk({nm, " match"}, 64'(match), 64'(ematch));
        chk({nm, " err"}, 64'(err), 64'(eerr));
        chk({nm, " key_valid"}, 64'(key_valid), 64'(kv_m));
        @(negedge clk);
        chk({nm, " busy_done_after"}, 64'({busy, done}), 64'd0);
        chk({nm, " chal_idle"}, 64'(chal), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({chal, osc_en, osc_clr, busy, done, response, hd, match, err, key_valid});
    endfunction

    initial begin
        logic [N_CHAL-1:0] base;
        logic [N_CHAL-1:0] noisy;
        int n_done;
        bit hit;
        base  = 32'h5555_5555;
        noisy = base ^ 32'h8000_0081;
        kv_m  = 0;
        key_m = '0;
        start = 0;
        mode  = 0;
        thresh = '0;
        set_pattern(base, 0, 0);
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_after_reset", all_outs(), 64'd0);

        run("nokey", 1, 6'd0, 0);
        run("enroll", 0, 6'd0, 1);
        run("auth_exact", 1, 6'd0, 0);
        set_pattern(noisy, 0, 0);
        run("auth_noisy_t2", 1, 6'd2, 0);
        run("auth_noisy_t3", 1, 6'd3, 0);
        set_pattern(base, 0, 1);
        run("tie_enroll", 0, 6'd0, 0);

        for (int i = 0; i < 6; i++) begin
            set_pattern(N_CHAL'($urandom), 1, 0);
            run("rand", (i == 0) ? 1'b0 : 1'($urandom), 6'($urandom_range(0, N_CHAL)), 0);
        end

        // Abort a run partway through with reset.
        set_pattern(N_CHAL'($urandom), 1, 0);
        @(negedge clk);
        mode  = 0;
        start = 1;
        hit   = 0;
        for (int c = 0; c < 3 * DONE_CYC; c++) begin
            @(negedge clk);
            start = 0;
            if (chal == 10) begin
                hit = 1;
                break;
            end
        end
        chk("reached_chal10", 64'(hit), 64'd1);
        rst_n = 0;
        @(negedge clk);
        chk("midrun_reset_outputs", all_outs(), 64'd0);
        rst_n = 1;
        kv_m  = 0;
        key_m = '0;
        n_done = 0;
        for (int c = 0; c < 2 * DONE_CYC; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("no_done_after_abort", 64'(n_done), 64'd0);

        run("nokey_after_abort", 1, 6'd5, 0);
        set_pattern(N_CHAL'($urandom), 1, 0);
        run("fresh_enroll", 0, 6'd0, 0);
        run("fresh_auth", 1, 6'd0, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
